// File: rtl/pll_reset_sequencer.sv
// Sequences PLL lock into staged system and CPU reset releases plus the
// 14 MHz / 7 MHz clock enables; PLL_RELOCK_REQ_EN adds a re-lock pulse on pll_rst.
module pll_reset_sequencer #(
   parameter int LOCK_CYCLES    = 1024,
   parameter int CPU_DELAY      = 256,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       cpu_rst_n,
   output logic       ce_14m,
   output logic       ce_7m,
   output logic       ce_7m_n,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_STABLE = 2'd1,
      S_SYS    = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 1);
   localparam logic [15:0] DELAY_LAST = 16'(CPU_DELAY - 1);

   state_t      state_q;
   state_t      state_nx;
   logic [1:0]  sync_q;
   logic        locked_s;
   logic [15:0] lock_cnt;
   logic [15:0] lock_nx;
   logic [15:0] delay_cnt;
   logic [15:0] delay_nx;
   logic [2:0]  div_q;
   logic [2:0]  div_nx;
   logic        sys_nx;
   logic        cpu_nx;

   assign state    = state_q;
   assign locked_s = sync_q[1];

   // pll_locked is asynchronous to clk; only locked_s may be used downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pll_locked};
      end
   end

   always_comb begin
      state_nx = state_q;
      lock_nx  = lock_cnt;
      delay_nx = delay_cnt;
      case (state_q)
         S_WAIT: begin
            if (locked_s) begin
               state_nx = S_STABLE;
               lock_nx  = 16'd0;
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_nx = S_WAIT;
            end else if (lock_cnt == LOCK_LAST) begin
               state_nx = S_SYS;
               delay_nx = 16'd0;
            end else begin
               lock_nx = lock_cnt + 16'd1;
            end
         end
         S_SYS: begin
            if (!locked_s) begin
               state_nx = S_WAIT;
            end else if (delay_cnt == DELAY_LAST) begin
               state_nx = S_RUN;
            end else begin
               delay_nx = delay_cnt + 16'd1;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               state_nx = S_WAIT;
            end
         end
         default: begin
            state_nx = S_WAIT;
         end
      endcase
   end

   // Resets and enables are registered from next-state values so they line up
   // with state and drop in the same cycle that lock loss is acted on.
   assign sys_nx = (state_nx == S_SYS) || (state_nx == S_RUN);
   assign cpu_nx = (state_nx == S_RUN);
   assign div_nx = (sys_nx && sys_rst_n) ? div_q + 3'd1 : 3'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_WAIT;
         lock_cnt  <= 16'd0;
         delay_cnt <= 16'd0;
         sys_rst_n <= 1'b0;
         cpu_rst_n <= 1'b0;
         div_q     <= 3'd0;
         ce_14m    <= 1'b0;
         ce_7m     <= 1'b0;
         ce_7m_n   <= 1'b0;
      end else begin
         state_q   <= state_nx;
         lock_cnt  <= lock_nx;
         delay_cnt <= delay_nx;
         sys_rst_n <= sys_nx;
         cpu_rst_n <= cpu_nx;
         div_q     <= div_nx;
         ce_14m    <= sys_nx && (div_nx[1:0] == 2'd3);
         ce_7m     <= sys_nx && (div_nx == 3'd7);
         ce_7m_n   <= sys_nx && (div_nx == 3'd3);
      end
   end

`ifdef PLL_RELOCK_REQ_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt;
   logic [3:0]    pulse_cnt;

   // Timeout runs only while staying in S_WAIT; a 16-cycle pll_rst pulse
   // follows each expiry, after which the timeout starts over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt   <= '0;
         pulse_cnt <= 4'd0;
         pll_rst   <= 1'b0;
      end else if ((state_q != S_WAIT) || (state_nx != S_WAIT)) begin
         tmo_cnt   <= '0;
         pulse_cnt <= 4'd0;
         pll_rst   <= 1'b0;
      end else if (pll_rst) begin
         if (pulse_cnt == 4'd15) begin
            pll_rst   <= 1'b0;
            pulse_cnt <= 4'd0;
            tmo_cnt   <= '0;
         end else begin
            pulse_cnt <= pulse_cnt + 4'd1;
         end
      end else if (tmo_cnt == TMO_LAST) begin
         pll_rst   <= 1'b1;
         pulse_cnt <= 4'd0;
         tmo_cnt   <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   // Always 0 for any legal TIMEOUT_CYCLES; no timeout logic is built.
   assign pll_rst = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024: continuous synchronized-lock cycles required before sys_rst_n release (range 2..65535).
REQ-002 SHALL have parameter CPU_DELAY, default 256: cycles between sys_rst_n release and cpu_rst_n release (range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576: cycles spent in S_WAIT before a PLL re-lock request (used only under REQ-026).
REQ-004 SHALL have port clk, input, 1: 57.27272 MHz system clock from the PLL; sole clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pll_locked, input, 1: PLL lock indicator, asynchronous to clk.
REQ-007 SHALL have port pll_rst, output, 1: active-high reset request to the PLL rst input.
REQ-008 SHALL have port sys_rst_n, output, 1: active-low reset for video/sound logic.
REQ-009 SHALL have port cpu_rst_n, output, 1: active-low reset for the CPUs.
REQ-010 SHALL have port ce_14m, output, 1: one-clk enable every 4 clk (14.31818 MHz rate).
REQ-011 SHALL have port ce_7m, output, 1: one-clk enable every 8 clk (7.15909 MHz rate).
REQ-012 SHALL have port ce_7m_n, output, 1: ce_7m phase shifted by 4 clk.
REQ-013 SHALL have port state, output, 2: current FSM state encoding.

Function
REQ-014 SHALL synchronize pll_locked through two clk flip-flops into locked_s; no other logic SHALL sample pll_locked directly.
REQ-015 SHALL implement states S_WAIT=0, S_STABLE=1, S_SYS=2, S_RUN=3, with state as a registered output.
REQ-016 S_WAIT: locked_s=1 -> S_STABLE with lock counter cleared to 0.
REQ-017 S_STABLE: locked_s=0 -> S_WAIT; otherwise increment lock counter; at counter==LOCK_CYCLES-1 -> S_SYS with delay counter cleared.
REQ-018 S_SYS: locked_s=0 -> S_WAIT; otherwise increment delay counter; at counter==CPU_DELAY-1 -> S_RUN.
REQ-019 S_RUN: locked_s=0 -> S_WAIT; otherwise hold.
REQ-020 Loss of lock in any state SHALL take priority over counter terminal count in the same cycle.
REQ-021 sys_rst_n SHALL be registered, 1 exactly when state is S_SYS or S_RUN; cpu_rst_n SHALL be registered, 1 exactly when state is S_RUN.
REQ-022 Divider: 3-bit counter held at 0 while sys_rst_n=0, incrementing modulo 8 otherwise; it SHALL restart from 0 after every re-release.
REQ-023 Registered enables: ce_14m=1 when divider[1:0]==3; ce_7m=1 when divider==7; ce_7m_n=1 when divider==3; all SHALL be 0 while sys_rst_n=0.
REQ-024 ce_7m and ce_7m_n SHALL never be 1 in the same cycle; each SHALL coincide with a ce_14m pulse.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=S_WAIT, synchronizer flops=0, all counters=0, sys_rst_n=0, cpu_rst_n=0, ce_14m=ce_7m=ce_7m_n=0, pll_rst=0; deassertion SHALL take effect on the next clk edge.

Configuration
REQ-026 With macro PLL_RELOCK_REQ_EN defined: a timeout counter SHALL run only in S_WAIT (cleared on leaving it); at TIMEOUT_CYCLES-1 it SHALL assert pll_rst for exactly 16 clk, then restart from 0; pll_rst SHALL be 0 outside S_WAIT.
REQ-027 Without PLL_RELOCK_REQ_EN: pll_rst SHALL be constant 0, no timeout counter SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-028 LOCK_CYCLES=16, CPU_DELAY=8; raise pll_locked at edge E -> state=S_STABLE by E+3, sys_rst_n=1 at E+19, cpu_rst_n=1 at E+27 (each +/-1 clk for synchronizer phase).
REQ-029 In S_RUN, drop pll_locked for 3 clk -> state=S_WAIT, sys_rst_n=cpu_rst_n=0 and all ce outputs 0 within 3 clk of the drop; full REQ-028 sequence repeats after re-lock.
REQ-030 In S_STABLE, glitch pll_locked low for 2 clk at lock count 10 -> return to S_WAIT, lock count restarts, sys_rst_n stays 0 throughout.
REQ-031 After sys_rst_n release, run 64 clk -> ce_14m exactly 16 pulses at period 4, ce_7m and ce_7m_n exactly 8 each at period 8, offset 4, never coincident.
REQ-032 PLL_RELOCK_REQ_EN defined, TIMEOUT_CYCLES=32, pll_locked held 0 -> pll_rst high for 16 clk starting 32 clk after reset release, repeating every 48 clk; without macro pll_rst stays 0.
REQ-033 Assert rst_n=0 mid-S_SYS -> all outputs reach reset values without a clk edge; after release, sequence restarts from S_WAIT.
